button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 173 +++++++++++++++++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, debouncer, edge pulses,
// long-press detection and auto-repeat, fully independent per channel.
module button_conditioner #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DBC_CYCLES   = 500000,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned LONG_CYCLES  = 50000000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] rpt_en,
  output logic [N_CH-1:0] out,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] edj,
  output logic [N_CH-1:0] rpt,
  output logic [N_CH-1:0] long_press
);

  localparam logic        REL_LVL  = (ACTIVE_LOW != 0);
  localparam int unsigned HOLD_MAX = (LONG_CYCLES > REPEAT_DELAY) ? LONG_CYCLES : REPEAT_DELAY;
  localparam int unsigned TMR_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int          DW       = $clog2(DBC_CYCLES + 1);
  localparam int          HW       = $clog2(HOLD_MAX + 1);
  localparam int          TW       = $clog2(TMR_MAX + 1);

  localparam logic [DW-1:0] DBC_LAST  = DW'(DBC_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);
  localparam logic [HW-1:0] LONG_PRE  = HW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic          DLY_ONE   = (REPEAT_DELAY == 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DW-1:0]          dbc_q, dbc_d;
    logic                   out_q, out_d;
    logic                   rise_q, fall_q, edj_q;
    logic [HW-1:0]          hold_q, hold_d;
    logic                   long_q, long_d;
    logic                   en_q;
    rpt_state_e             st_q, st_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic                   rpt_q, rpt_d;
    logic                   trig;

    assign s = sync_q[SYNC_STAGES-1] ^ REL_LVL;

    // State registers; synchroniser resets to the released pin level.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {SYNC_STAGES{REL_LVL}};
        dbc_q  <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        edj_q  <= 1'b0;
        hold_q <= '0;
        long_q <= 1'b0;
        en_q   <= 1'b0;
        st_q   <= ST_IDLE;
        tmr_q  <= '0;
        rpt_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[ch]};
        dbc_q  <= dbc_d;
        out_q  <= out_d;
        rise_q <= out_d & ~out_q;
        fall_q <= ~out_d & out_q;
        edj_q  <= out_d ^ out_q;
        hold_q <= hold_d;
        long_q <= long_d;
        en_q   <= rpt_en[ch];
        st_q   <= st_d;
        tmr_q  <= tmr_d;
        rpt_q  <= rpt_d;
      end
    end

    // Debounce counter and held-time counter; hold reads 0 in the rise cycle.
    always_comb begin
      dbc_d  = '0;
      out_d  = out_q;
      hold_d = '0;
      if (s != out_q) begin
        if (dbc_q == DBC_LAST) begin
          out_d = ~out_q;
        end else begin
          dbc_d = dbc_q + 1'b1;
        end
      end else begin
        dbc_d = '0;
      end
      if (out_q && out_d) begin
        hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
      end else begin
        hold_d = '0;
      end
      long_d = out_q && out_d && (hold_q == LONG_PRE);
    end

    // Auto-repeat: the triggering cycle counts as timer 0.
    always_comb begin
      st_d  = st_q;
      tmr_d = tmr_q;
      rpt_d = 1'b0;
      trig  = rpt_en[ch] && out_q && (rise_q || !en_q);
      case (st_q)
        ST_IDLE: begin
          tmr_d = '0;
          if (trig && DLY_ONE) begin
            st_d  = ST_REPEAT;
            rpt_d = 1'b1;
          end else if (trig) begin
            st_d  = ST_DELAY;
            tmr_d = TMR_ONE;
          end else begin
            st_d  = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (tmr_q == DLY_LAST) begin
            st_d  = ST_REPEAT;
            tmr_d = '0;
            rpt_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (tmr_q == RATE_LAST) begin
            tmr_d = '0;
            rpt_d = 1'b1;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        default: begin
          st_d  = ST_IDLE;
          tmr_d = '0;
        end
      endcase
      // Release or disable wins on the same edge and suppresses any pulse.
      if (!out_d || !rpt_en[ch]) begin
        st_d  = ST_IDLE;
        tmr_d = '0;
        rpt_d = 1'b0;
      end else begin
        rpt_d = rpt_d;
      end
    end

    assign out[ch]        = out_q;
    assign rise[ch]       = rise_q;
    assign fall[ch]       = fall_q;
    assign edj[ch]        = edj_q;
    assign rpt[ch]        = rpt_q;
    assign long_press[ch] = long_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// pin activity, all checked every cycle against a window/run-length model.
module tb_button_conditioner;

  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DBC  = 4;
  localparam int LONG = 20;
  localparam int RD   = 10;
  localparam int RATE = 3;
  localparam int SZ   = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in, rpt_en;
  logic [3:0] out, rise, fall, edj, rpt, long_press;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  // Model history, indexed by cycle: raw pin sampled at the edge that starts
  // the cycle, normalised synchronised level, debounced level, rpt_en level,
  // and length of the run of cycles with out & rpt_en both high.
  logic [3:0] p_h [SZ];
  logic [3:0] s_h [SZ];
  logic [3:0] o_h [SZ];
  logic [3:0] e_h [SZ];
  int         run_h [SZ][4];
  int         rise_at [4];

  always #5 clk = ~clk;

  button_conditioner #(
    .N_CH(N), .SYNC_STAGES(SYNC), .DBC_CYCLES(DBC), .ACTIVE_LOW(1),
    .LONG_CYCLES(LONG), .REPEAT_DELAY(RD), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .rpt_en(rpt_en),
    .out(out), .rise(rise), .fall(fall), .edj(edj), .rpt(rpt),
    .long_press(long_press)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cur);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"},  out,        32'h0);
    chk({tag, "_rise"}, rise,       32'h0);
    chk({tag, "_fall"}, fall,       32'h0);
    chk({tag, "_edj"},  edj,        32'h0);
    chk({tag, "_rpt"},  rpt,        32'h0);
    chk({tag, "_long"}, long_press, 32'h0);
  endtask

  // After a reset everything looks released: pin high, level low, no runs.
  task automatic model_reset();
    for (int i = 1; i <= 8; i++) begin
      p_h[cur+i] = 4'hF;
      s_h[cur+i] = 4'h0;
      o_h[cur+i] = 4'h0;
      e_h[cur+i] = 4'h0;
      for (int c = 0; c < 4; c++) run_h[cur+i][c] = 0;
    end
    cur = cur + 8;
    for (int c = 0; c < 4; c++) rise_at[c] = -1000;
  endtask

  // Drive one cycle, advance the model by one edge and compare every output.
  task automatic step(input logic [3:0] pin, input logic [3:0] en);
    logic [3:0] xr, xf, xp, xl;
    logic       tog;
    in       = pin;
    rpt_en   = en;
    e_h[cur] = en;
    @(posedge clk);
    #1;
    cur++;
    p_h[cur] = pin;
    s_h[cur] = ~p_h[cur-SYNC+1];
    for (int c = 0; c < 4; c++) begin
      run_h[cur-1][c] = (o_h[cur-1][c] && e_h[cur-1][c]) ? run_h[cur-2][c] + 1 : 0;
      tog = 1'b1;
      for (int j = cur - DBC; j < cur; j++) begin
        if (s_h[j][c] == o_h[cur-1][c] || o_h[j][c] != o_h[cur-1][c]) tog = 1'b0;
      end
      o_h[cur][c] = o_h[cur-1][c] ^ tog;
      if (o_h[cur][c] && !o_h[cur-1][c]) rise_at[c] = cur;
      xr[c] = o_h[cur][c] & ~o_h[cur-1][c];
      xf[c] = ~o_h[cur][c] & o_h[cur-1][c];
      xp[c] = o_h[cur][c] && (run_h[cur-1][c] >= RD) && (((run_h[cur-1][c] - RD) % RATE) == 0);
      xl[c] = o_h[cur][c] && ((cur - rise_at[c]) == LONG);
    end
    chk("m_out",  out,        o_h[cur]);
    chk("m_rise", rise,       xr);
    chk("m_fall", fall,       xf);
    chk("m_edj",  edj,        xr | xf);
    chk("m_rpt",  rpt,        xp);
    chk("m_long", long_press, xl);
  endtask

  initial begin
    logic [3:0] acc;
    logic [3:0] pins, ens;
    int         n_rpt, n_long, k;
    int         dur [4];

    rst_n  = 1'b0;
    in     = 4'hF;
    rpt_en = 4'h0;
    model_reset();
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) step(4'hF, 4'h0);

    // Clean press on channel 0: accepted on the 6th edge, rise for one cycle.
    repeat (5) step(4'hE, 4'h0);
    chk("p031_pre_out", out, 32'h0);
    step(4'hE, 4'h0);
    chk("p031_out", out, 32'h1);
    chk("p031_rise", rise, 32'h1);
    step(4'hE, 4'h0);
    chk("p031_rise_once", rise, 32'h0);
    repeat (8) step(4'hF, 4'h0);

    // Three-cycle glitch on channel 1 must be ignored.
    acc = 4'h0;
    repeat (3) begin step(4'hD, 4'h0); acc = acc | out | rise | fall; end
    repeat (10) begin step(4'hF, 4'h0); acc = acc | out | rise | fall; end
    chk("p032_quiet", acc, 32'h0);

    // Channel 2 held 40 cycles with repeat enabled.
    n_rpt = 0; n_long = 0;
    for (int i = 1; i <= 40; i++) begin
      step(4'hB, 4'h4);
      n_rpt  += int'(rpt[2]);
      n_long += int'(long_press[2]);
      if (i == 16) chk("p033_rpt10", rpt, 32'h4);
      if (i == 26) chk("p033_long20", long_press, 32'h4);
    end
    repeat (5) begin
      step(4'hF, 4'h4);
      n_rpt  += int'(rpt[2]);
      n_long += int'(long_press[2]);
    end
    step(4'hF, 4'h4);
    chk("p033_fall", fall, 32'h4);
    repeat (8) begin step(4'hF, 4'h4); n_rpt += int'(rpt[2]); end
    chk("p033_rpt_count", n_rpt, 32'd10);
    chk("p033_long_count", n_long, 32'd1);

    // Channel 3: repeat disabled during held counts 12..14.
    repeat (6) step(4'h7, 4'h8);
    chk("p034_rise", rise, 32'h8);
    for (int h = 0; h < 32; h++) begin
      step(4'h7, (h >= 12 && h < 15) ? 4'h0 : 4'h8);
      if (h == 9)  chk("p034_rpt10", rpt, 32'h8);
      if (h == 12) chk("p034_no_rpt13", rpt, 32'h0);
      if (h == 24) chk("p034_rpt25", rpt, 32'h8);
    end
    repeat (8) step(4'hF, 4'h0);

    // Reset mid-press on channel 0, then re-acceptance after release.
    repeat (11) step(4'hE, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("p035_rst");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) step(4'hE, 4'h0);
    chk("p035_pre_out", out, 32'h0);
    step(4'hE, 4'h0);
    chk("p035_rise", rise, 32'h1);
    repeat (8) step(4'hF, 4'h0);

    // All channels pressed on the same edge.
    repeat (5) step(4'h0, 4'h0);
    step(4'h0, 4'h0);
    chk("p036_rise", rise, 32'hF);
    chk("p036_out", out, 32'hF);
    repeat (8) step(4'hF, 4'h0);

    // Random bounces, long holds and rpt_en toggling on every channel.
    pins = 4'hF;
    ens  = 4'h0;
    for (int c = 0; c < 4; c++) dur[c] = int'($urandom_range(1, 40));
    for (int i = 0; i < 900; i++) begin
      for (int c = 0; c < 4; c++) begin
        dur[c]--;
        if (dur[c] <= 0) begin
          pins[c] = ~pins[c];
          dur[c]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 45));
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        k = int'($urandom_range(0, 3));
        ens[k] = ~ens[k];
      end
      step(pins, ens);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
